// File: rtl/uart_receiver.sv
// UART receive stage: synchronises rx, validates the start bit, samples each
// bit at mid-period, assembles an LSB-first word and offers it on valid/ready.
// Framing errors (stop bit low) and overruns (new word while valid held) are
// reported as one-cycle pulses.
//
// Handshake: valid is a level that stays high until the cycle after
// valid && ready; ready is ignored while valid is low; data is stable while
// valid is high unless an overrun replaces it.
module uart_receiver #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1736
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy,
  output logic [3:0]       bit_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Mid-start-bit sample point and full-bit sample point for the cycle counter.
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(WIDTH - 1);

  state_t           state;
  logic [15:0]      cnt;
  logic [WIDTH-1:0] shreg;
  logic             rx_m;
  logic             rx_s;
  logic             rx_d;

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Two-flop synchroniser plus one delayed copy of rx_s for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // Receive FSM with registered data, handshake and error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      bit_count <= '0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // Consumer handshake; a word latched later in this block overrides it.
      if (valid && ready) valid <= 1'b0;

      case (state)
        IDLE: begin
          // Only a true high-to-low edge starts a frame, so a held-low break
          // must return high before the next frame is accepted.
          if (rx_d && !rx_s) begin
            state     <= START;
            cnt       <= '0;
            bit_count <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            if (!rx_s) begin
              state     <= DATA;
              cnt       <= '0;
              bit_count <= '0;
            end else begin
              state <= IDLE;  // glitch shorter than half a bit
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            // Shifting in from the top leaves bit 0 at the LSB after WIDTH bits.
            shreg     <= {rx_s, shreg[WIDTH-1:1]};
            cnt       <= '0;
            bit_count <= bit_count + 4'd1;
            if (bit_count == LAST_BIT) state <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          // Leave at mid-stop-bit so a following start edge is not missed.
          if (cnt == BIT_LAST) begin
            state <= IDLE;
            if (rx_s) begin
              data    <= shreg;
              valid   <= 1'b1;
              overrun <= valid && !ready;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at CLKS_PER_BIT=16: frames are built bit by bit from
// the word value, and accepted words are checked against an expected queue.
module tb_uart_receiver;

  localparam int W = 8;
  localparam int C = 16;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         rx;
  logic         ready;
  logic [W-1:0] data;
  logic         valid;
  logic         frame_err;
  logic         overrun;
  logic         busy;
  logic [3:0]   bit_count;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_receiver #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .ready     (ready),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy),
    .bit_count (bit_count),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] last_word = '0;
  int           n_ferr = 0;
  int           n_ovr = 0;
  int           n_vrise = 0;
  int           busy_cyc = 0;
  int           vrise_cyc = 0;
  logic         valid_q = 1'b0;

  // Monitor on the falling edge: records accepted words and event pulses.
  always @(negedge clk) begin
    if (valid && ready) got_q.push_back(data);
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (valid && !valid_q) begin
      n_vrise++;
      vrise_cyc = cyc;
    end
    valid_q = valid;
    if (busy) busy_cyc++;
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serial frame: start 0, WIDTH data bits LSB first, then the stop level.
  task automatic send_frame(input logic [W-1:0] w, input logic stop);
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < W; i++) begin
      rx = w[i];
      tick(C);
    end
    rx = stop;
    tick(C);
    rx = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; ready = 1'b0;
    tick(3);
    n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h exp 00", data); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", valid); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (bit_count !== 4'd0) begin n_err++; $display("FAIL reset_bit_count got %0d exp 0", bit_count); end
    reset = 1'b0;
    tick(4);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_single();
    int t0, fe0, lat;
    ready = 1'b1;
    got_q.delete(); exp_q.delete();
    fe0 = n_ferr;
    t0 = cyc;
    send_frame(8'h99, 1'b1);
    exp_q.push_back(8'h99); last_word = 8'h99;
    tick(4);
    lat = vrise_cyc - t0;
    n_vec++; if (lat < 154 || lat > 156) begin n_err++; $display("FAIL single_latency got %0d exp 155+-1", lat); end
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL single_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL single_data got %h exp %h", got_q[i], exp_q[i]); end
    end
    n_vec++; if (bit_count !== 4'd8) begin n_err++; $display("FAIL single_bit_count got %0d exp 8", bit_count); end
    n_vec++; if (n_ferr - fe0 !== 0) begin n_err++; $display("FAIL single_frame_err got %0d exp 0", n_ferr - fe0); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL single_valid_clear got %b exp 0", valid); end
  endtask

  task automatic test_back_to_back();
    int ov0;
    ready = 1'b1;
    got_q.delete(); exp_q.delete();
    ov0 = n_ovr;
    send_frame(8'h0E, 1'b1);
    send_frame(8'h70, 1'b1);
    exp_q.push_back(8'h0E); exp_q.push_back(8'h70); last_word = 8'h70;
    tick(4);
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (n_ovr - ov0 !== 0) begin n_err++; $display("FAIL b2b_overrun got %0d exp 0", n_ovr - ov0); end
  endtask

  task automatic test_frame_err();
    int fe0, vr0;
    ready = 1'b1;
    fe0 = n_ferr; vr0 = n_vrise;
    send_frame(8'h55, 1'b0);
    tick(C);
    n_vec++; if (n_ferr - fe0 !== 1) begin n_err++; $display("FAIL ferr_pulses got %0d exp 1", n_ferr - fe0); end
    n_vec++; if (n_vrise - vr0 !== 0) begin n_err++; $display("FAIL ferr_valid got %0d exp 0", n_vrise - vr0); end
    n_vec++; if (data !== last_word) begin n_err++; $display("FAIL ferr_data got %h exp %h", data, last_word); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy got %b exp 0", busy); end
  endtask

  task automatic test_glitch();
    int b0, vr0, fe0, ov0, nb;
    b0 = busy_cyc; vr0 = n_vrise; fe0 = n_ferr; ov0 = n_ovr;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(3 * C);
    nb = busy_cyc - b0;
    n_vec++; if (nb < 6 || nb > 10) begin n_err++; $display("FAIL glitch_busy_cycles got %0d exp about 8", nb); end
    n_vec++; if (n_vrise - vr0 !== 0) begin n_err++; $display("FAIL glitch_valid got %0d exp 0", n_vrise - vr0); end
    n_vec++; if ((n_ferr - fe0) + (n_ovr - ov0) !== 0) begin n_err++; $display("FAIL glitch_flags got %0d exp 0", (n_ferr - fe0) + (n_ovr - ov0)); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy got %b exp 0", busy); end
  endtask

  task automatic test_overrun();
    int ov0;
    ready = 1'b0;
    got_q.delete(); exp_q.delete();
    ov0 = n_ovr;
    send_frame(8'hA5, 1'b1);
    tick(2);
    n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL ovr_first_valid got %b exp 1", valid); end
    n_vec++; if (data !== 8'hA5) begin n_err++; $display("FAIL ovr_first_data got %h exp a5", data); end
    send_frame(8'h3C, 1'b1);
    tick(2);
    n_vec++; if (n_ovr - ov0 !== 1) begin n_err++; $display("FAIL ovr_pulses got %0d exp 1", n_ovr - ov0); end
    n_vec++; if (data !== 8'h3C) begin n_err++; $display("FAIL ovr_data got %h exp 3c", data); end
    n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid got %b exp 1", valid); end
    ready = 1'b1;
    exp_q.push_back(8'h3C); last_word = 8'h3C;
    tick(1);
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL ovr_valid_clear got %b exp 0", valid); end
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL ovr_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovr_accept got %h exp %h", got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int vr0;
    ready = 1'b1;
    got_q.delete(); exp_q.delete();
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      tick(C);
    end
    tick(C / 2);
    n_vec++; if (bit_count !== 4'd4) begin n_err++; $display("FAIL mid_bit_count got %0d exp 4", bit_count); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got %b exp 1", busy); end
    reset = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_busy got %b exp 0", busy); end
    n_vec++; if (bit_count !== 4'd0) begin n_err++; $display("FAIL async_bit_count got %0d exp 0", bit_count); end
    n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL async_data got %h exp 00", data); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL async_valid got %b exp 0", valid); end
    tick(2);
    reset = 1'b0;
    vr0 = n_vrise;
    tick(2 * C);
    n_vec++; if (n_vrise - vr0 !== 0) begin n_err++; $display("FAIL mid_no_valid got %0d exp 0", n_vrise - vr0); end
    send_frame(8'h12, 1'b1);
    exp_q.push_back(8'h12); last_word = 8'h12;
    tick(4);
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL mid_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL mid_next_data got %h exp %h", got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    int ov0, fe0;
    ready = 1'b1;
    got_q.delete(); exp_q.delete();
    ov0 = n_ovr; fe0 = n_ferr;
    for (int k = 0; k < 10; k++) begin
      w = W'($urandom_range(0, 255));
      send_frame(w, 1'b1);
      exp_q.push_back(w); last_word = w;
      tick($urandom_range(0, 12));
    end
    tick(C);
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if ((n_ovr - ov0) + (n_ferr - fe0) !== 0) begin n_err++; $display("FAIL rand_flags got %0d exp 0", (n_ovr - ov0) + (n_ferr - fe0)); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART receive stage that consumes the serial line driven by the team's transmitter.
- Synchronises the asynchronous rx line, detects and validates the start bit, and samples each bit at mid-period.
- Assembles a WIDTH-bit word, LSB first, and presents it on a valid/ready handshake.
- Flags framing errors and overruns.

Parameters:
- WIDTH, 8: data bits per frame.
- CLKS_PER_BIT, 1736: clk cycles per bit period (100 MHz / 57600 baud); legal range 4 to 65535.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- ready  input  1  consumer accepts data when ready and valid are both high.
- data  output  WIDTH  received word.
- valid  output  1  data holds an unconsumed word.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: new word arrived while valid was still high.
- busy  output  1  frame reception in progress (state is not IDLE).
- bit_count  output  4  data bits captured in the current frame, 0..WIDTH.

Behaviour:
- Reset (async assert, sync deassert via clk edge): data=0, valid=0, frame_err=0, overrun=0, busy=0, bit_count=0, state=IDLE, both synchroniser flops=1.
- Synchroniser: two flops; rx_s is the second flop output. All logic uses rx_s only.
- Internal bit counter: cnt, 16 bits wide.
- IDLE:
  - A high-to-low transition of rx_s moves the state to START and loads cnt=0.
  - busy asserts the same edge.
- START:
  - Increment cnt.
  - When cnt reaches CLKS_PER_BIT/2 - 1 (integer division), sample rx_s.
  - Low: move to DATA, cnt=0, bit_count=0.
  - High: glitch; return to IDLE with no flags.
- DATA:
  - Increment cnt. When cnt reaches CLKS_PER_BIT-1, sample rx_s into shift-register bit [bit_count], set cnt=0, increment bit_count.
  - When bit_count reaches WIDTH, move to STOP.
- STOP:
  - When cnt reaches CLKS_PER_BIT-1, sample rx_s.
  - High: data <= shift register, valid <= 1.
  - Low: frame_err pulses for one cycle; data and valid unchanged; word discarded.
  - In both cases, the next state is IDLE and busy drops.
  - The return to IDLE happens at mid-stop-bit, allowing back-to-back frames.
- bit_count:
  - Holds WIDTH from entering STOP until the next start edge.
  - Resets to 0 when START is entered.
- Handshake:
  - valid is a level signal.
  - valid clears on the cycle after ready and valid are both high.
  - ready is ignored while valid is low.
  - data is stable while valid is high, except on overrun.
- Overrun: if the stop sample is good while valid is high and ready is low on that cycle, then data is overwritten, valid stays 1, and overrun pulses for one cycle.
- Simultaneous events: if ready accepts on the same cycle a new word latches, the new word wins; valid stays 1 and there is no overrun.
- Latency: valid rises 2 + CLKS_PER_BIT/2 + (WIDTH+1)*CLKS_PER_BIT + 1 clk cycles after the rx falling edge, within ±1 cycle.
- Framing-error break: a break (rx held low) produces frame_err once. The block then waits in IDLE for rx_s to go high and then low again before accepting the next frame.
- Reset mid-frame: the frame is aborted immediately; no valid or flag is produced.

Test Plan:
- CLKS_PER_BIT=16, ready=1, send 0x99 (frame 0,1,0,0,1,1,0,0,1,1) -> valid pulses once with data=0x99 at about 2+8+144+1=155 cycles after the start edge; bit_count ends at 8; frame_err=0.
- Back-to-back 0x0E then 0x70 with no idle gap, ready=1 -> two valid handshakes in order (0x0E, then 0x70); no overrun.
- 0x55 sent with the stop bit forced low -> frame_err pulses once, valid stays 0, data keeps its previous value, busy returns to 0.
- rx low pulse of 4 cycles (shorter than CLKS_PER_BIT/2) -> START aborts, no valid or flags, busy high for about 8 cycles then 0.
- ready=0, send 0xA5 then 0x3C -> valid=1 with data=0xA5; on the second frame, overrun pulses and data=0x3C; then assert ready -> valid clears the next cycle.
- Assert reset during DATA at bit 4 of 0xFF -> all outputs return to reset values asynchronously; the next clean frame 0x12 is received correctly.
